// File: rtl/sram_fifo_ctrl_72x256_pkg.sv
// Shared constants and SRAM port bundle types for the 72x256 SRAM-backed FIFO.
// Latency: n/a (type and constant definitions only).
// Backpressure: n/a.
package sram_fifo_pkg;

    localparam int DATA_WIDTH  = 72;
    localparam int ADDR_WIDTH  = 8;
    localparam int NUM_WMASKS  = DATA_WIDTH / 8;
    localparam int DEPTH       = 2 ** ADDR_WIDTH;
    localparam int OBUF_DEPTH  = 2;
    // mem_count must hold DEPTH itself, so one bit wider than the address.
    localparam int CNT_WIDTH   = ADDR_WIDTH + 1;
    // level covers DEPTH words in the macro plus up to 2 in flight/buffered.
    localparam int LEVEL_WIDTH = ADDR_WIDTH + 2;

    // Write-port bundle as seen by the macro (all selects active-low).
    typedef struct packed {
        logic                  csb;
        logic                  web;
        logic [NUM_WMASKS-1:0] wmask;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } sram_wr_t;

    // Read-port request bundle; data returns one cycle after the sampling edge.
    typedef struct packed {
        logic                  csb;
        logic [ADDR_WIDTH-1:0] addr;
    } sram_rd_t;

endpackage

// File: rtl/sram_fifo_ctrl_72x256_if.sv
// Streaming push/pop handshake bundle plus occupancy for the SRAM FIFO.
// Latency: n/a (wiring only).
// Backpressure: push side via push_ready, pop side via pop_ready.
interface sram_fifo_ctrl_72x256_if;
    import sram_fifo_pkg::*;

    logic                   push_valid;
    logic                   push_ready;
    logic [DATA_WIDTH-1:0]  push_data;
    logic                   pop_valid;
    logic                   pop_ready;
    logic [DATA_WIDTH-1:0]  pop_data;
    logic [LEVEL_WIDTH-1:0] level;

    // Producer/consumer side.
    modport master (
        output push_valid, push_data, pop_ready,
        input  push_ready, pop_valid, pop_data, level
    );

    // FIFO controller side.
    modport slave (
        input  push_valid, push_data, pop_ready,
        output push_ready, pop_valid, pop_data, level
    );

endinterface

// File: rtl/sram_fifo_ctrl_72x256_obuf.sv
// Two-entry output buffer that absorbs the SRAM read latency in front of the pop port.
// Latency: captured word is presented at pop_data the edge after capture.
// Backpressure: pop_ready stalls the head; the controller never captures into a full buffer.
module sram_fifo_obuf
    import sram_fifo_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  i_cap_vld,
    input  logic [DATA_WIDTH-1:0] i_cap_dat,
    input  logic                  i_pop_rdy,
    output logic                  o_pop_vld,
    output logic [DATA_WIDTH-1:0] o_pop_dat,
    output logic [1:0]            o_ob_count
);

    logic [1:0]            r_count;
    logic [DATA_WIDTH-1:0] r_head;
    logic [DATA_WIDTH-1:0] r_tail;
    logic                  w_pop;

    assign w_pop      = i_pop_rdy & (r_count != 2'd0);
    assign o_pop_vld  = (r_count != 2'd0);
    assign o_pop_dat  = r_head;
    assign o_ob_count = r_count;

    // Shift-style 2-entry queue: head is always the oldest word; data regs need no reset.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_count <= 2'd0;
        end else begin
            unique case ({i_cap_vld, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) r_head <= i_cap_dat;
                    else                 r_tail <= i_cap_dat;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_head  <= r_tail;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    // Popping the only entry: the new word becomes head directly.
                    if (r_count == 2'd1) begin
                        r_head <= i_cap_dat;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= i_cap_dat;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/sram_fifo_ctrl_72x256.sv
// Presents the 72x256 1rw1r SRAM macro as a streaming FIFO with a 2-word prefetch buffer.
// Latency: push at edge E is poppable after edge E+2 when empty; 1 word/cycle sustained.
// Backpressure: push_ready drops when 256 words sit in the macro; reads stall on a full buffer.
module sram_fifo_ctrl_72x256
    import sram_fifo_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    sram_fifo_ctrl_72x256_if.slave  bus,
    output logic                    sram_write_csb,
    output logic                    sram_write_web,
    output logic [NUM_WMASKS-1:0]   sram_write_wmask,
    output logic [ADDR_WIDTH-1:0]   sram_write_addr,
    output logic [DATA_WIDTH-1:0]   sram_write_data,
    output logic                    sram_read_csb,
    output logic [ADDR_WIDTH-1:0]   sram_read_addr,
    input  logic [DATA_WIDTH-1:0]   sram_read_data
);

    logic [ADDR_WIDTH-1:0] r_wptr;
    logic [ADDR_WIDTH-1:0] r_rptr;
    logic [CNT_WIDTH-1:0]  r_mem_count;
    logic                  r_inflight;

    logic                  w_clr;
    logic                  w_push_fire;
    logic                  w_wr_en;
    logic                  w_pop_fire;
    logic                  w_rd_issue;
    logic [1:0]            w_ob_count;
    logic                  w_pop_vld;
    logic [DATA_WIDTH-1:0] w_pop_dat;
    sram_wr_t              w_wr;
    sram_rd_t              w_rd;

    assign w_clr       = rst | flush;
    assign bus.push_ready = (r_mem_count < CNT_WIDTH'(DEPTH)) & ~rst;
    assign w_push_fire = bus.push_valid & bus.push_ready;
    // A word offered during flush is dropped, so it must not reach the macro either.
    assign w_wr_en     = w_push_fire & ~flush;
    assign w_pop_fire  = w_pop_vld & bus.pop_ready;

    // Issue only if the buffer will have room once the in-flight word lands;
    // written as a sum comparison so the pop credit never underflows.
    assign w_rd_issue  = ~w_clr & (r_mem_count != '0) &
                         (({1'b0, w_ob_count} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop_fire}));

    // Macro port bundles; web tracks csb so a selected write port always writes.
    always_comb begin
        w_wr       = '0;
        w_wr.csb   = ~w_wr_en;
        w_wr.web   = ~w_wr_en;
        w_wr.wmask = '1;
        w_wr.addr  = r_wptr;
        w_wr.data  = bus.push_data;
        w_rd       = '0;
        w_rd.csb   = ~w_rd_issue;
        w_rd.addr  = r_rptr;
    end

    assign sram_write_csb   = w_wr.csb;
    assign sram_write_web   = w_wr.web;
    assign sram_write_wmask = w_wr.wmask;
    assign sram_write_addr  = w_wr.addr;
    assign sram_write_data  = w_wr.data;
    assign sram_read_csb    = w_rd.csb;
    assign sram_read_addr   = w_rd.addr;

    // Pointers, macro occupancy and the one-cycle read-in-flight flag.
    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_mem_count <= '0;
            r_inflight  <= 1'b0;
        end else begin
            if (w_wr_en)    r_wptr <= r_wptr + 1'b1;
            if (w_rd_issue) r_rptr <= r_rptr + 1'b1;
            r_mem_count <= r_mem_count + CNT_WIDTH'(w_wr_en) - CNT_WIDTH'(w_rd_issue);
            r_inflight  <= w_rd_issue;
        end
    end

    sram_fifo_obuf u_obuf (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .i_cap_vld  (r_inflight),
        .i_cap_dat  (sram_read_data),
        .i_pop_rdy  (bus.pop_ready),
        .o_pop_vld  (w_pop_vld),
        .o_pop_dat  (w_pop_dat),
        .o_ob_count (w_ob_count)
    );

    assign bus.pop_valid = w_pop_vld;
    assign bus.pop_data  = w_pop_dat;
    assign bus.level     = LEVEL_WIDTH'(r_mem_count) + LEVEL_WIDTH'(r_inflight) +
                           LEVEL_WIDTH'(w_ob_count);

endmodule

// File: tb/tb_sram_fifo_ctrl_72x256.sv
// Directed bench for the SRAM-backed FIFO with a behavioural 1rw1r macro model.
// Latency: n/a.
// Backpressure: n/a.
module tb_sram_fifo_ctrl_72x256;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        sram_write_csb;
    logic        sram_write_web;
    logic [8:0]  sram_write_wmask;
    logic [7:0]  sram_write_addr;
    logic [71:0] sram_write_data;
    logic        sram_read_csb;
    logic [7:0]  sram_read_addr;
    logic [71:0] sram_read_data;
    logic [71:0] mem [0:255];

    int n_checks = 0;
    int n_errors = 0;
    int pushed;
    int popped;

    sram_fifo_ctrl_72x256_if bus ();

    sram_fifo_ctrl_72x256 dut (
        .clk              (clk),
        .rst              (rst),
        .flush            (flush),
        .bus              (bus),
        .sram_write_csb   (sram_write_csb),
        .sram_write_web   (sram_write_web),
        .sram_write_wmask (sram_write_wmask),
        .sram_write_addr  (sram_write_addr),
        .sram_write_data  (sram_write_data),
        .sram_read_csb    (sram_read_csb),
        .sram_read_addr   (sram_read_addr),
        .sram_read_data   (sram_read_data)
    );

    always #5 clk = ~clk;

    // Macro model: registered read, data valid the cycle after the address edge.
    always @(posedge clk) begin
        if (!sram_write_csb && !sram_write_web) mem[sram_write_addr] <= sram_write_data;
        if (!sram_read_csb) sram_read_data <= mem[sram_read_addr];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        bus.push_valid = 1'b0; bus.push_data = '0; bus.pop_ready = 1'b0;
        step(); step();
        #1;
        chk("rst_push_ready", bus.push_ready, 0);
        chk("rst_pop_valid", bus.pop_valid, 0);
        chk("rst_level", bus.level, 0);
        chk("rst_wr_csb", sram_write_csb, 1);
        chk("rst_rd_csb", sram_read_csb, 1);
        rst = 1'b0; #1;
        chk("post_rst_push_ready", bus.push_ready, 1);

        // Single word through an empty FIFO.
        step();
        bus.push_valid = 1'b1; bus.push_data = 72'h0A_DEADBEEF_CAFEF00D; #1;
        chk("single_wr_csb", sram_write_csb, 0);
        chk("single_wr_web", sram_write_web, 0);
        chk("single_wr_addr", sram_write_addr, 0);
        chk("single_wr_data", sram_write_data, 72'h0A_DEADBEEF_CAFEF00D);
        chk("single_wr_wmask", sram_write_wmask, 9'h1FF);
        step();
        bus.push_valid = 1'b0; #1;
        chk("single_e0_level", bus.level, 1);
        chk("single_e0_pop_valid", bus.pop_valid, 0);
        chk("single_e0_rd_csb", sram_read_csb, 0);
        chk("single_e0_rd_addr", sram_read_addr, 0);
        step(); #1;
        chk("single_e1_pop_valid", bus.pop_valid, 0);
        chk("single_e1_level", bus.level, 1);
        chk("single_e1_rd_csb", sram_read_csb, 1);
        step(); #1;
        chk("single_e2_pop_valid", bus.pop_valid, 1);
        chk("single_e2_pop_data", bus.pop_data, 72'h0A_DEADBEEF_CAFEF00D);
        chk("single_e2_level", bus.level, 1);
        bus.pop_ready = 1'b1;
        step();
        bus.pop_ready = 1'b0; #1;
        chk("single_popped_valid", bus.pop_valid, 0);
        chk("single_popped_level", bus.level, 0);

        // 512 words streaming, crossing the pointer wrap twice.
        bus.pop_ready = 1'b1; pushed = 0; popped = 0;
        for (int k = 0; k < 515; k++) begin
            bus.push_valid = (pushed < 512);
            bus.push_data  = 72'(pushed);
            #1;
            if (bus.push_valid && bus.push_ready) pushed++;
            if (bus.pop_valid) begin
                chk("stream_data", bus.pop_data, 80'(popped));
                popped++;
            end
            step();
        end
        chk("stream_pushed", 32'(pushed), 512);
        chk("stream_popped", 32'(popped), 512);
        chk("stream_end_level", bus.level, 0);

        // Fill with the consumer stalled.
        bus.pop_ready = 1'b0; pushed = 0;
        for (int k = 0; k < 300; k++) begin
            bus.push_valid = 1'b1;
            bus.push_data  = 72'(1000 + pushed);
            #1;
            if (!sram_read_csb && !sram_write_csb)
                chk("fill_no_collision", sram_read_addr != sram_write_addr, 1);
            if (bus.push_ready) pushed++;
            step();
        end
        chk("fill_pushed", 32'(pushed), 258);
        chk("fill_level", bus.level, 258);
        chk("fill_push_ready", bus.push_ready, 0);
        chk("fill_pop_valid", bus.pop_valid, 1);
        chk("fill_head", bus.pop_data, 1000);
        bus.pop_ready = 1'b1;
        step();
        bus.pop_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            bus.push_data = 72'(1000 + pushed);
            #1;
            if (bus.push_ready) pushed++;
            step();
        end
        chk("fill_one_more", 32'(pushed), 259);
        chk("fill_refull_level", bus.level, 258);
        bus.push_valid = 1'b0; bus.pop_ready = 1'b1; popped = 0;
        for (int k = 0; k < 300; k++) begin
            #1;
            if (bus.pop_valid) begin
                chk("drain_data", bus.pop_data, 80'(1001 + popped));
                popped++;
            end
            step();
        end
        chk("drain_count", 32'(popped), 258);
        chk("drain_level", bus.level, 0);

        // Flush with 5 words stored, one read in flight and one buffered.
        bus.pop_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            bus.push_valid = 1'b1; bus.push_data = 72'(2000 + k);
            step();
        end
        bus.push_valid = 1'b0;
        step(); step(); step(); #1;
        chk("preflush_level", bus.level, 8);
        bus.pop_ready = 1'b1;
        step();
        bus.pop_ready = 1'b0; #1;
        chk("preflush_level2", bus.level, 7);
        flush = 1'b1; bus.push_valid = 1'b1; bus.push_data = 72'hBAD;
        step();
        flush = 1'b0; bus.push_valid = 1'b0; #1;
        chk("flush_level", bus.level, 0);
        chk("flush_pop_valid", bus.pop_valid, 0);
        step(); step(); #1;
        chk("flush_no_stale", bus.pop_valid, 0);
        bus.push_valid = 1'b1; bus.push_data = 72'h55;
        step();
        bus.push_valid = 1'b0;
        step(); step(); #1;
        chk("postflush_valid", bus.pop_valid, 1);
        chk("postflush_data", bus.pop_data, 72'h55);
        chk("postflush_level", bus.level, 1);
        bus.pop_ready = 1'b1;
        step();
        bus.pop_ready = 1'b0; #1;
        chk("postflush_empty", bus.pop_valid, 0);
        chk("postflush_level0", bus.level, 0);

        // Reset pulse in the middle of a stream.
        bus.pop_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            bus.push_valid = 1'b1; bus.push_data = 72'(3000 + k);
            step();
        end
        rst = 1'b1; #1;
        chk("midrst_push_ready", bus.push_ready, 0);
        chk("midrst_wr_csb", sram_write_csb, 1);
        chk("midrst_rd_csb", sram_read_csb, 1);
        step(); #1;
        chk("midrst_level", bus.level, 0);
        chk("midrst_pop_valid", bus.pop_valid, 0);
        rst = 1'b0; bus.push_valid = 1'b0; #1;
        chk("midrst_push_ready_after", bus.push_ready, 1);
        step(); step(); step(); #1;
        chk("midrst_no_stale", bus.pop_valid, 0);
        chk("midrst_level_after", bus.level, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
